serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, meaning operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to add the operands; sampled on the rising clk edge.
REQ-005 a  input  WIDTH  operand A; sampled only on the cycle start is accepted.
REQ-006 b  input  WIDTH  operand B; sampled only on the cycle start is accepted.
REQ-007 sum  output  WIDTH  registered result of a+b modulo 2^WIDTH.
REQ-008 cout  output  1  registered final carry (see Configuration).
REQ-009 busy  output  1  high while an addition is in progress.
REQ-010 done  output  1  single-cycle pulse when sum/cout become valid.

Function
REQ-011 The block SHALL compute the sum bit-serially, LSB first, one bit per clock, using two half-adder stages plus an OR for carry per bit.
REQ-012 The FSM SHALL have states IDLE, RUN and DONE, encoded in 2 bits, with the unused encoding returning to IDLE.
REQ-013 In IDLE with start=1, the block SHALL load a and b into shift registers, clear the carry register and bit counter, and enter RUN.
REQ-014 In IDLE with start=0, the block SHALL remain in IDLE with all outputs holding their values.
REQ-015 In RUN, each cycle SHALL consume bit 0 of both shift registers plus the carry register, shift the sum bit into sum MSB, shift both operands right, update carry, and increment the counter.
REQ-016 After exactly WIDTH RUN cycles (counter wraps at WIDTH-1), the FSM SHALL enter DONE.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle and the FSM SHALL return to IDLE unconditionally.
REQ-018 busy SHALL equal 1 in RUN only.
REQ-019 Latency: start sampled at edge N SHALL yield done=1 in the cycle following edge N+WIDTH+1.
REQ-020 start asserted in RUN or DONE SHALL be ignored, with no effect on operands, counter or result.
REQ-021 sum and cout SHALL hold their final values from DONE until the next accepted start.
REQ-022 a and b changing outside the accepting cycle SHALL not affect the result.

Reset
REQ-023 rst=1 SHALL immediately force state=IDLE, sum=0, cout=0, busy=0, done=0, carry=0, counter=0, independent of clk.
REQ-024 rst asserted during RUN SHALL abort the operation, produce no done pulse, and require a new start after release.
REQ-025 start on the first edge after rst deasserts SHALL be accepted normally.

Configuration
REQ-026 With macro SERIAL_ADD_COUT_EN defined, cout SHALL carry the final carry out of bit WIDTH-1, latched on entry to DONE.
REQ-027 Without SERIAL_ADD_COUT_EN, cout SHALL be tied to 0, and the carry register SHALL still be used internally.

Verification
REQ-028 WIDTH=8, a=8'h0F, b=8'h01, start pulse -> busy for 8 cycles, done pulse, sum=8'h10, cout=0.
REQ-029 a=8'hFF, b=8'h01 -> sum=8'h00; cout=1 with SERIAL_ADD_COUT_EN, cout=0 without it.
REQ-030 a=8'hA5, b=8'h5A, start held high for 12 cycles -> exactly one addition, sum=8'hFF, one done pulse, next start accepted only after return to IDLE.
REQ-031 a=8'h3C, b=8'h44, rst pulsed in the 4th RUN cycle -> outputs are immediately 0, no done pulse, state is IDLE.
REQ-032 Back-to-back: start in the IDLE cycle right after done with a=8'h80, b=8'h80 -> sum=8'h00, cout=1 (macro on), and the previous sum is held until that run's done.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Purpose : bit-serial WIDTH-bit adder (LSB first, two half adders + OR per bit) under an IDLE/RUN/DONE FSM.
// Latency : start accepted at edge N -> sum/cout updated at edge N+WIDTH, done pulse in the cycle after edge N+WIDTH+1.
// Backpressure: none; start is only honoured in IDLE and ignored while busy or in DONE.
// Optional feature: define SERIAL_ADD_COUT_EN to expose the final carry on cout (otherwise cout is tied to 0).
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_done;
    logic [CW-1:0]    r_cnt;

    logic             w_ha1_s;
    logic             w_ha1_c;
    logic             w_ha2_s;
    logic             w_ha2_c;
    logic             w_carry_nxt;
    logic             w_last;
    logic [WIDTH-1:0] w_acc_nxt;

    // Per-bit full adder built from two half adders; carry is the OR of both half-adder carries.
    assign w_ha1_s     = r_op_a[0] ^ r_op_b[0];
    assign w_ha1_c     = r_op_a[0] & r_op_b[0];
    assign w_ha2_s     = w_ha1_s ^ r_carry;
    assign w_ha2_c     = w_ha1_s & r_carry;
    assign w_carry_nxt = w_ha1_c | w_ha2_c;

    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign w_acc_nxt   = {w_ha2_s, r_acc[WIDTH-1:1]};
    assign w_last      = (r_cnt == CW'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; the unused encoding falls back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: load operands on accept, shift one bit per RUN cycle, publish the result on the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            // done is registered off DONE so it coincides with the first IDLE cycle after the run.
            r_done <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op_a  <= a;
                        r_op_b  <= b;
                        r_acc   <= '0;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_op_a  <= r_op_a >> 1;
                    r_op_b  <= r_op_b >> 1;
                    r_acc   <= w_acc_nxt;
                    r_carry <= w_carry_nxt;
                    r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
                    // The visible sum only changes here, so the previous result holds during a run.
                    if (w_last) begin
                        r_sum <= w_acc_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SERIAL_ADD_COUT_EN
    logic r_cout;

    // Latch the carry out of the MSB on entry to DONE and hold it until the next result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cout <= 1'b0;
        end else if (r_state == S_RUN && w_last) begin
            r_cout <= w_carry_nxt;
        end
    end

    assign cout = r_cout;
`else
    assign cout = 1'b0;
`endif

    assign sum  = r_sum;
    assign busy = (r_state == S_RUN);
    assign done = r_done;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: transaction-level timing model plus directed literal checks and random traffic.
// The model records the accept edge of each addition and derives busy/done/sum timing from it arithmetically.
// cout expectation follows SERIAL_ADD_COUT_EN when the bench is compiled with the same macro set.
module tb_serial_add_ctrl;

    localparam int W = 8;

`ifdef SERIAL_ADD_COUT_EN
    localparam bit COUT_EN = 1'b1;
`else
    localparam bit COUT_EN = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    wire  [W-1:0] sum;
    wire          cout;
    wire          busy;
    wire          done;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp_v);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint       ecnt   = 0;
    longint       t_acc  = 0;
    bit           act    = 1'b0;
    logic [W-1:0] p_sum  = '0;
    logic         p_c    = 1'b0;
    logic [W-1:0] m_sum  = '0;
    logic         m_cout = 1'b0;
    bit           m_busy = 1'b0;
    bit           m_done = 1'b0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            act    = 1'b0;
            m_sum  = '0;
            m_cout = 1'b0;
            m_busy = 1'b0;
            m_done = 1'b0;
        end else begin
            ecnt++;
            m_done = 1'b0;
            if (act) begin
                if (ecnt == t_acc + W) begin
                    m_sum  = p_sum;
                    m_cout = p_c;
                end else if (ecnt == t_acc + W + 1) begin
                    act    = 1'b0;
                    m_done = 1'b1;
                end
            end else if (start) begin
                act          = 1'b1;
                t_acc        = ecnt;
                {p_c, p_sum} = {1'b0, a} + {1'b0, b};
                if (!COUT_EN) p_c = 1'b0;
            end
            m_busy = act && (ecnt < t_acc + W);
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("cyc_sum",  sum,  m_sum);
            chk("cyc_cout", cout, m_cout);
            chk("cyc_busy", busy, m_busy);
            chk("cyc_done", done, m_done);
        end
    end

    // Wait (bounded) for a done pulse; deasserts start after the first cycle.
    task automatic wait_done(input int limit, output int busy_cnt);
        bit seen;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL wait_done: no done pulse within %0d cycles", limit);
        end
    endtask

    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, output int busy_cnt);
        a     = va;
        b     = vb;
        start = 1'b1;
        wait_done(40, busy_cnt);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int bc;
        int dcnt;

        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_sum",  sum,  0);
        chk("rst_cout", cout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        // 0x0F + 0x01
        run_op(8'h0F, 8'h01, bc);
        chk("t1_busy_cycles", bc, 8);
        chk("t1_sum", sum, 32'h10);
        chk("t1_cout", cout, 0);
        chk("t1_model_sum", m_sum, 32'h10);

        // 0xFF + 0x01 wraps
        run_op(8'hFF, 8'h01, bc);
        chk("t2_sum", sum, 32'h00);
        chk("t2_cout", cout, {31'd0, COUT_EN});
        chk("t2_model_cout", m_cout, {31'd0, COUT_EN});

        // start held high for 12 cycles
        a     = 8'hA5;
        b     = 8'h5A;
        start = 1'b1;
        dcnt  = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) begin
                dcnt++;
                chk("t3_sum", sum, 32'hFF);
            end
            if (i == 9)  chk("t3_idle_before_reaccept", busy, 0);
            if (i == 10) chk("t3_reaccept_busy", busy, 1);
        end
        start = 1'b0;
        chk("t3_done_pulses", dcnt, 1);
        repeat (14) @(negedge clk);

        // reset in the 4th RUN cycle
        a     = 8'h3C;
        b     = 8'h44;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t4_sum", sum, 0);
        chk("t4_cout", cout, 0);
        chk("t4_busy", busy, 0);
        chk("t4_done", done, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        chk("t4_no_done_after_abort", dcnt, 0);

        // start on the first edge after reset release
        #1 rst = 1'b1;
        @(negedge clk);
        a     = 8'h3C;
        b     = 8'h44;
        start = 1'b1;
        #2 rst = 1'b0;
        wait_done(40, bc);
        chk("t5_busy_cycles", bc, 8);
        chk("t5_sum", sum, 32'h80);

        // back-to-back start in the done cycle
        run_op(8'h11, 8'h22, bc);
        chk("t6a_sum", sum, 32'h33);
        a     = 8'h80;
        b     = 8'h80;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t6_hold_sum", sum, 32'h33);
        chk("t6_busy", busy, 1);
        wait_done(40, bc);
        chk("t6_busy_cycles", bc, 7);
        chk("t6_sum", sum, 32'h00);
        chk("t6_cout", cout, {31'd0, COUT_EN});

        // random traffic with stray starts, operand churn and occasional aborts
        for (int k = 0; k < 60; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            a     = W'($urandom);
            b     = W'($urandom);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int c = 0; c < W + 4; c++) begin
                start = ($urandom_range(0, 3) == 0);
                a     = W'($urandom);
                b     = W'($urandom);
                if (c == 4 && $urandom_range(0, 9) == 0) begin
                    #1 rst = 1'b1;
                    #2 rst = 1'b0;
                end
                @(negedge clk);
            end
            start = 1'b0;
        end
        repeat (15) @(negedge clk);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
